// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 constants and per-axis timing structs
// for reuse by the timing generator, the pattern stage and later display modes.
package vga_pkg;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
        logic        pol;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    localparam int   DEF_CORDW  = 10;
    localparam int   DEF_H_RES  = 640;
    localparam int   DEF_H_FP   = 16;
    localparam int   DEF_H_SYNC = 96;
    localparam int   DEF_H_BP   = 48;
    localparam int   DEF_V_RES  = 480;
    localparam int   DEF_V_FP   = 10;
    localparam int   DEF_V_SYNC = 2;
    localparam int   DEF_V_BP   = 33;
    localparam logic DEF_H_POL  = 1'b0;
    localparam logic DEF_V_POL  = 1'b0;

    localparam vga_timing_t VGA_640X480 = '{
        h: '{res: 16'(DEF_H_RES), fp: 16'(DEF_H_FP), sync: 16'(DEF_H_SYNC),
             bp: 16'(DEF_H_BP), pol: DEF_H_POL},
        v: '{res: 16'(DEF_V_RES), fp: 16'(DEF_V_FP), sync: 16'(DEF_V_SYNC),
             bp: 16'(DEF_V_BP), pol: DEF_V_POL}
    };

    function automatic int axis_total(input int res, input int fp, input int sync, input int bp);
        return res + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with terminal count plus combinational sync/active/first decode.
// The top registers the decode so horizontal and vertical outputs stay aligned.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int W    = 10,
    parameter int RES  = 640,
    parameter int FP   = 16,
    parameter int SYNC = 96,
    parameter int BP   = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] pos,
    output logic         tc,
    output logic         sync_on,
    output logic         active,
    output logic         first
);

    localparam int             TOTAL     = axis_total(RES, FP, SYNC, BP);
    localparam logic [W-1:0]   LAST      = W'(TOTAL - 1);
    // Decode compares use one extra bit so a window ending at 2**W cannot alias to zero.
    localparam logic [W:0]     RES_X     = (W+1)'(RES);
    localparam logic [W:0]     SYNC_BEG  = (W+1)'(RES + FP);
    localparam logic [W:0]     SYNC_END  = (W+1)'(RES + FP + SYNC);

    logic [W-1:0] cnt_r;
    logic [W:0]   cnt_x_s;

    // Position counter: advances on inc, wraps to zero after the last position.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (inc) begin
            cnt_r <= (cnt_r == LAST) ? '0 : cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_x_s = {1'b0, cnt_r};
    assign pos     = cnt_r;
    assign tc      = inc && (cnt_r == LAST);
    assign sync_on = (cnt_x_s >= SYNC_BEG) && (cnt_x_s < SYNC_END);
    assign active  = cnt_x_s < RES_X;
    assign first   = cnt_r == '0;

endmodule

// File: rtl/vga_timing.sv
// Pixel-clock raster timing generator: sync, data-enable, coordinates and frame/line strobes,
// all registered from the same counter state so every output describes the same pixel.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   CORDW  = DEF_CORDW,
    parameter int   H_RES  = DEF_H_RES,
    parameter int   H_FP   = DEF_H_FP,
    parameter int   H_SYNC = DEF_H_SYNC,
    parameter int   H_BP   = DEF_H_BP,
    parameter int   V_RES  = DEF_V_RES,
    parameter int   V_FP   = DEF_V_FP,
    parameter int   V_SYNC = DEF_V_SYNC,
    parameter int   V_BP   = DEF_V_BP,
    parameter logic H_POL  = DEF_H_POL,
    parameter logic V_POL  = DEF_V_POL
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame,
    output logic             line,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy
);

    localparam int H_TOTAL   = axis_total(H_RES, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL   = axis_total(V_RES, V_FP, V_SYNC, V_BP);
    localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    if ((longint'(1) << CORDW) < longint'(MAX_TOTAL)) begin : g_cordw_check
        $error("vga_timing: CORDW=%0d too narrow for total %0d", CORDW, MAX_TOTAL);
    end

    logic [CORDW-1:0] h_pos_s;
    logic [CORDW-1:0] v_pos_s;
    logic             h_tc_s;
    logic             v_tc_unused;
    logic             h_sync_s;
    logic             v_sync_s;
    logic             h_act_s;
    logic             v_act_s;
    logic             h_first_s;
    logic             v_first_s;

    vga_axis_counter #(
        .W(CORDW), .RES(H_RES), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h (
        .clk(clk_pix), .rst(rst_pix), .inc(1'b1),
        .pos(h_pos_s), .tc(h_tc_s), .sync_on(h_sync_s), .active(h_act_s), .first(h_first_s)
    );

    vga_axis_counter #(
        .W(CORDW), .RES(V_RES), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v (
        .clk(clk_pix), .rst(rst_pix), .inc(h_tc_s),
        .pos(v_pos_s), .tc(v_tc_unused), .sync_on(v_sync_s), .active(v_act_s), .first(v_first_s)
    );

    // Output register: one cycle behind the counters, reset forces the idle levels.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            sx    <= '0;
            sy    <= '0;
            de    <= 1'b0;
            frame <= 1'b0;
            line  <= 1'b0;
            hsync <= ~H_POL;
            vsync <= ~V_POL;
        end else begin
            sx    <= h_pos_s;
            sy    <= v_pos_s;
            de    <= h_act_s && v_act_s;
            frame <= h_first_s && v_first_s;
            line  <= h_first_s;
            hsync <= h_sync_s ? H_POL : ~H_POL;
            vsync <= v_sync_s ? V_POL : ~V_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default 640x480 timing plus a mid-size and a tiny
// active-high configuration, each checked against hand-computed vector tables.
module tb_vga_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_d, rst_m, rst_s;
    logic       d_hs, d_vs, d_de, d_fr, d_ln;
    logic [9:0] d_sx, d_sy;
    logic       m_hs, m_vs, m_de, m_fr, m_ln;
    logic [4:0] m_sx, m_sy;
    logic       s_hs, s_vs, s_de, s_fr, s_ln;
    logic [2:0] s_sx, s_sy;

    vga_timing u_dflt (
        .clk_pix(clk), .rst_pix(rst_d), .hsync(d_hs), .vsync(d_vs), .de(d_de),
        .frame(d_fr), .line(d_ln), .sx(d_sx), .sy(d_sy)
    );

    vga_timing #(
        .CORDW(5), .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_RES(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .H_POL(1'b0), .V_POL(1'b0)
    ) u_mid (
        .clk_pix(clk), .rst_pix(rst_m), .hsync(m_hs), .vsync(m_vs), .de(m_de),
        .frame(m_fr), .line(m_ln), .sx(m_sx), .sy(m_sy)
    );

    vga_timing #(
        .CORDW(3), .H_RES(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1)
    ) u_small (
        .clk_pix(clk), .rst_pix(rst_s), .hsync(s_hs), .vsync(s_vs), .de(s_de),
        .frame(s_fr), .line(s_ln), .sx(s_sx), .sy(s_sy)
    );

    typedef struct {
        int   n;
        int   sx;
        int   sy;
        logic hs;
        logic vs;
        logic de;
        logic fr;
        logic ln;
    } vec_t;

    vec_t tbl[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic vec_t mk(int n, int sx, int sy, logic hs, logic vs, logic de,
                                logic fr, logic ln);
        vec_t v;
        v.n = n; v.sx = sx; v.sy = sy; v.hs = hs; v.vs = vs; v.de = de; v.fr = fr; v.ln = ln;
        return v;
    endfunction

    function automatic void cmp(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic sample(input int d, output int sx, output int sy, output logic hs,
                          output logic vs, output logic de, output logic fr, output logic ln);
        case (d)
            0: begin sx = d_sx; sy = d_sy; hs = d_hs; vs = d_vs; de = d_de; fr = d_fr; ln = d_ln; end
            1: begin sx = m_sx; sy = m_sy; hs = m_hs; vs = m_vs; de = m_de; fr = m_fr; ln = m_ln; end
            default: begin sx = s_sx; sy = s_sy; hs = s_hs; vs = s_vs; de = s_de; fr = s_fr; ln = s_ln; end
        endcase
    endtask

    task automatic check_vec(input int d, input string tag, input vec_t v);
        int sx, sy;
        logic hs, vs, de, fr, ln;
        sample(d, sx, sy, hs, vs, de, fr, ln);
        cmp($sformatf("dut%0d %s n=%0d sx", d, tag, v.n), sx, v.sx);
        cmp($sformatf("dut%0d %s n=%0d sy", d, tag, v.n), sy, v.sy);
        cmp($sformatf("dut%0d %s n=%0d hsync", d, tag, v.n), int'(hs), int'(v.hs));
        cmp($sformatf("dut%0d %s n=%0d vsync", d, tag, v.n), int'(vs), int'(v.vs));
        cmp($sformatf("dut%0d %s n=%0d de", d, tag, v.n), int'(de), int'(v.de));
        cmp($sformatf("dut%0d %s n=%0d frame", d, tag, v.n), int'(fr), int'(v.fr));
        cmp($sformatf("dut%0d %s n=%0d line", d, tag, v.n), int'(ln), int'(v.ln));
    endtask

    // Steps cycles n0..n1 after reset release, applies matching table rows, accumulates counts.
    task automatic run(input int d, input int n0, input int n1, input int htot, input int vtot,
                       input int hres, input int vres, output int c_de, output int c_fr,
                       output int c_ln, output int c_hl, output int c_vl, output int c_pos,
                       output int c_bad);
        int sx, sy, k;
        logic hs, vs, de, fr, ln;
        k = 0;
        c_de = 0; c_fr = 0; c_ln = 0; c_hl = 0; c_vl = 0; c_pos = 0; c_bad = 0;
        for (int n = n0; n <= n1; n++) begin
            @(negedge clk);
            sample(d, sx, sy, hs, vs, de, fr, ln);
            c_de += int'(de); c_fr += int'(fr); c_ln += int'(ln);
            c_hl += int'(!hs); c_vl += int'(!vs);
            if (sx != n % htot || sy != (n / htot) % vtot) c_pos++;
            if (de && (sx >= hres || sy >= vres)) c_bad++;
            while (k < tbl.size() && tbl[k].n == n) begin
                check_vec(d, "run", tbl[k]);
                k++;
            end
        end
        cmp($sformatf("dut%0d table rows reached", d), k, tbl.size());
    endtask

    int c_de, c_fr, c_ln, c_hl, c_vl, c_pos, c_bad;

    initial begin
        rst_d = 1'b1; rst_m = 1'b1; rst_s = 1'b1;
        repeat (5) @(negedge clk);
        check_vec(0, "reset", mk(-1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        check_vec(1, "reset", mk(-1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        check_vec(2, "reset", mk(-1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Default 640x480: first three lines.
        tbl = {};
        tbl.push_back(mk(0,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(1,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(639,  639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(640,  640, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(655,  655, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(656,  656, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(751,  751, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(752,  752, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(799,  799, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(800,  0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1455, 655, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1456, 656, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2399, 799, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        rst_d = 1'b0;
        run(0, 0, 2399, 800, 525, 640, 480, c_de, c_fr, c_ln, c_hl, c_vl, c_pos, c_bad);
        cmp("dflt de cycles 3 lines", c_de, 1920);
        cmp("dflt frame strobes", c_fr, 1);
        cmp("dflt line strobes", c_ln, 3);
        cmp("dflt hsync low cycles", c_hl, 288);
        cmp("dflt vsync low cycles", c_vl, 0);
        cmp("dflt position errors", c_pos, 0);
        cmp("dflt de outside active", c_bad, 0);

        // Default: run on to (300,20), then reset mid-frame.
        tbl = {};
        tbl.push_back(mk(16300, 300, 20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        run(0, 2400, 16300, 800, 525, 640, 480, c_de, c_fr, c_ln, c_hl, c_vl, c_pos, c_bad);
        cmp("dflt position errors to (300,20)", c_pos, 0);
        rst_d = 1'b1;
        @(negedge clk);
        check_vec(0, "midreset", mk(-1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        rst_d = 1'b0;
        @(negedge clk);
        check_vec(0, "rerelease", mk(0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        @(negedge clk);
        check_vec(0, "rerelease", mk(1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));

        // Mid-size active-low config: 24x19 total, one full frame plus the wrap.
        tbl = {};
        tbl.push_back(mk(0,   0,  0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(17,  17, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(18,  18, 0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(20,  20, 0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(21,  21, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(23,  23, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(24,  0,  1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(288, 0,  12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(336, 0,  14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(383, 23, 15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(384, 0,  16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(455, 23, 18, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(456, 0,  0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        rst_m = 1'b0;
        run(1, 0, 456, 24, 19, 16, 12, c_de, c_fr, c_ln, c_hl, c_vl, c_pos, c_bad);
        cmp("mid de cycles", c_de, 193);
        cmp("mid frame strobes", c_fr, 2);
        cmp("mid line strobes", c_ln, 20);
        cmp("mid hsync low cycles", c_hl, 57);
        cmp("mid vsync low cycles", c_vl, 48);
        cmp("mid position errors", c_pos, 0);
        cmp("mid de outside active", c_bad, 0);

        // Tiny active-high config: 7x6 total, CORDW=3.
        tbl = {};
        tbl.push_back(mk(0,  0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(3,  3, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(4,  4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(5,  5, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(6,  6, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(7,  0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(28, 0, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(33, 5, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(35, 0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(41, 6, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(42, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        rst_s = 1'b0;
        run(2, 0, 42, 7, 6, 4, 3, c_de, c_fr, c_ln, c_hl, c_vl, c_pos, c_bad);
        cmp("small de cycles", c_de, 13);
        cmp("small frame strobes", c_fr, 2);
        cmp("small line strobes", c_ln, 7);
        cmp("small hsync low cycles", c_hl, 37);
        cmp("small vsync low cycles", c_vl, 36);
        cmp("small position errors", c_pos, 0);
        cmp("small de outside active", c_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
